mem_arbiter: RTL

Two-requester arbiter that shares the single cache-line memory port between the instruction cache and the data cache. It sits between both caches and main memory, and owns the `mem_req`/`mem_gnt`/`mem_rvalid`/`write_done` handshake. It serialises one line transaction at a time: a line read for either cache, or a line write-back for the data cache. A watchdog bounds each transaction's response time.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache-line memory port between I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: DC fixed priority).
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 20,
  parameter int CACHE_LINE_BYTES = 16,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ic_req_i,
  input  logic [ADDR_WIDTH-1:0]         ic_addr_i,
  output logic                          ic_gnt_o,
  output logic                          ic_rvalid_o,
  input  logic                          dc_req_i,
  input  logic                          dc_we_i,
  input  logic [ADDR_WIDTH-1:0]         dc_addr_i,
  input  logic [8*CACHE_LINE_BYTES-1:0] dc_wdata_i,
  output logic                          dc_gnt_o,
  output logic                          dc_rvalid_o,
  output logic                          dc_write_done_o,
  output logic [8*CACHE_LINE_BYTES-1:0] rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [8*CACHE_LINE_BYTES-1:0] mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic                          mem_write_done_i,
  input  logic [8*CACHE_LINE_BYTES-1:0] mem_rdata_i,
  output logic                          busy_o,
  output logic                          owner_o,
  output logic                          err_o
);

  localparam int LINE_BITS = 8*CACHE_LINE_BYTES;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [LINE_BITS-1:0]   wdata_q;
  logic                   owner_q;
  logic [CW-1:0]          wd_q;
  logic [CW-1:0]          wd_d;

  logic                   latch;
  logic                   pick_dc;
  logic                   gnt;
  logic                   done;
  logic                   expire;
  logic                   rsp_hit;

`ifdef MEM_ARB_RR_EN
  // rr_q remembers the last latched requester (1 = DC)
  logic rr_q;

  assign pick_dc = dc_req_i && (!ic_req_i || !rr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b1;
    end else if (latch) begin
      rr_q <= pick_dc;
    end
  end
`else
  assign pick_dc = dc_req_i;
`endif

  // Only the response matching the latched direction completes
  assign rsp_hit = we_q ? mem_write_done_i : mem_rvalid_i;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    latch   = 1'b0;
    gnt     = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          latch   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt_i) begin
          gnt  = 1'b1;
          wd_d = '0;
          if (rsp_hit) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rsp_hit) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (WD_EN && wd_q == WD_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (latch) begin
        owner_q <= pick_dc;
        addr_q  <= pick_dc ? dc_addr_i : ic_addr_i;
        we_q    <= pick_dc && dc_we_i;
        wdata_q <= pick_dc ? dc_wdata_i : '0;
      end
    end
  end

  assign mem_req_o   = (state_q == S_ISSUE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign ic_gnt_o        = gnt && !owner_q;
  assign dc_gnt_o        = gnt && owner_q;
  assign ic_rvalid_o     = done && !we_q && !owner_q;
  assign dc_rvalid_o     = done && !we_q && owner_q;
  assign dc_write_done_o = done && we_q && owner_q;

  assign rdata_o = mem_rdata_i;
  assign busy_o  = (state_q != S_IDLE);
  assign owner_o = owner_q;
  assign err_o   = expire;

endmodule
